// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the sequential multiply/divide unit:
// operation encodings, FSM state enum and op decode helpers.
package muldiv_seq_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    function automatic logic op_is_div(input op_t o);
        return o[1];
    endfunction

    function automatic logic op_is_signed(input op_t o);
        return ~o[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add for multiply, restoring
// shift-subtract for divide, on unsigned magnitudes held in acc_hi/acc_lo.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             div_mode,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        diff    = shifted - {1'b0, operand};
        nxt_hi  = sum[WIDTH:1];
        nxt_lo  = {sum[0], acc_lo[WIDTH-1:1]};
        if (div_mode) begin
            // Remainder stays below the divisor, so diff[WIDTH] is a clean borrow flag.
            if (!diff[WIDTH]) begin
                nxt_hi = diff[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = shifted[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit with MIPS-style HI/LO registers.
// valid/ready: start is accepted only when busy is low; done pulses once per accepted start.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output state_t           state
);

    state_t           nxt_state;
    op_t              op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] acc_hi, acc_lo, operand;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [CNT_W-1:0] cnt;
    logic             neg_q, rneg_q, divzero_q;

    logic             a_neg, b_neg, is_div, b_zero;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_mode (is_div),
        .acc_hi   (acc_hi),
        .acc_lo   (acc_lo),
        .operand  (operand),
        .nxt_hi   (step_hi),
        .nxt_lo   (step_lo)
    );

    always_comb begin
        is_div   = op_is_div(op_q);
        b_zero   = (b_q == '0);
        a_neg    = op_is_signed(op_q) & a_q[WIDTH-1];
        b_neg    = op_is_signed(op_q) & b_q[WIDTH-1];
        a_mag    = a_neg ? -a_q : a_q;
        b_mag    = b_neg ? -b_q : b_q;
        prod     = {acc_hi, acc_lo};
        prod_fix = neg_q ? -prod : prod;
        {fix_hi, fix_lo} = prod_fix;
        if (is_div) begin
            fix_lo = neg_q  ? -acc_lo : acc_lo;
            fix_hi = rneg_q ? -acc_hi : acc_hi;
        end
    end

    always_comb begin
        nxt_state = state;
        case (state)
            S_IDLE: if (start) nxt_state = S_PREP;
            S_PREP: nxt_state = (is_div && b_zero) ? S_DONE : S_RUN;
            S_RUN:  if (cnt == CNT_W'(WIDTH - 1)) nxt_state = S_FIX;
            S_FIX:  nxt_state = S_DONE;
            S_DONE: nxt_state = S_IDLE;
            default: nxt_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            op_q      <= OP_MULT;
            a_q       <= '0;
            b_q       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            operand   <= '0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            divzero_q <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            state <= nxt_state;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q <= op_t'(op);
                        a_q  <= a;
                        b_q  <= b;
                    end
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                end
                S_PREP: begin
                    acc_hi    <= '0;
                    acc_lo    <= a_mag;
                    operand   <= b_mag;
                    cnt       <= '0;
                    neg_q     <= a_neg ^ b_neg;
                    rneg_q    <= a_neg;
                    divzero_q <= is_div & b_zero;
                end
                S_RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + CNT_W'(1);
                end
                S_FIX: begin
                    hi <= fix_hi;
                    lo <= fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign divzero = done & divzero_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq at WIDTH=32 with hand-computed results.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b, wdata;
    logic         hi_we, lo_we;
    logic         busy, done, divzero;
    logic [W-1:0] hi, lo;
    state_t       state;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    muldiv_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .divzero(divzero), .hi(hi), .lo(lo),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and wait (bounded) for done.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input int lat, input logic [W-1:0] eh,
                          input logic [W-1:0] el, input logic edz);
        int cycles;
        logic [63:0] e;
        exp_q.push_back({eh, el});
        start = 1'b1; op = o; a = av; b = bv;
        next_cycle();
        start = 1'b0;
        cycles = 1;
        while (!done && cycles < 100) begin
            next_cycle();
            cycles++;
        end
        e = exp_q.pop_front();
        check({tag, "_lat"}, 64'(cycles), 64'(lat));
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_hilo"}, {hi, lo}, e);
        check({tag, "_dz"}, 64'(divzero), 64'(edz));
        next_cycle();
        check({tag, "_idle"}, {62'd0, done, busy}, 64'd0);
    endtask

    initial begin
        int seen;
        reset = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (2) next_cycle();
        check("rst_ctrl", {61'd0, busy, done, divzero}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        reset = 1'b1;
        next_cycle();

        run_op("mult_7_m3", OP_MULT, 32'd7, 32'hFFFF_FFFD, 35, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_minmin", OP_MULT, 32'h8000_0000, 32'h8000_0000, 35, 32'h4000_0000, 32'h0, 1'b0);
        run_op("mult_negneg", OP_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFB, 35, 32'h0, 32'd10, 1'b0);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 35, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 35, 32'h0, 32'h8000_0000, 1'b0);
        run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 35, 32'd1, 32'hFFFF_FFFD, 1'b0);
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 35, 32'd2, 32'd14, 1'b0);
        run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h0001_0000, 35, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0);

        // Preload via direct writes, then divide by zero must leave them intact.
        hi_we = 1'b1; wdata = 32'h11;
        next_cycle();
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
        next_cycle();
        lo_we = 1'b0;
        check("preload", {hi, lo}, {32'h11, 32'h22});
        run_op("divu_zero", OP_DIVU, 32'd100, 32'd0, 2, 32'h11, 32'h22, 1'b1);
        run_op("div_zero", OP_DIV, 32'hFFFF_FF00, 32'd0, 2, 32'h11, 32'h22, 1'b1);

        // Direct write together with start: write lands, op still runs.
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5A;
        start = 1'b1; op = OP_MULTU; a = 32'd2; b = 32'd3;
        next_cycle();
        hi_we = 1'b0; lo_we = 1'b0; start = 1'b0;
        check("we_start_hilo", {hi, lo}, {32'h5A, 32'h5A});
        check("we_start_busy", 64'(busy), 64'd1);
        seen = 1;
        while (!done && seen < 100) begin next_cycle(); seen++; end
        check("we_start_res", {hi, lo}, {32'd0, 32'd6});
        next_cycle();

        // Start and hi_we mid-run are ignored.
        start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd5;
        next_cycle();
        start = 1'b0;
        repeat (9) next_cycle();
        start = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD; op = OP_DIVU; a = 32'd9; b = 32'd0;
        next_cycle();
        start = 1'b0; hi_we = 1'b0;
        check("ign_hi_mid", 64'(hi), 64'd0);
        seen = 11;
        while (!done && seen < 100) begin next_cycle(); seen++; end
        check("ign_lat", 64'(seen), 64'd35);
        check("ign_res", {hi, lo}, {32'd0, 32'd15});
        next_cycle();
        repeat (3) next_cycle();
        check("ign_no_restart", {62'd0, busy, done}, 64'd0);

        // Reset in the middle of RUN.
        start = 1'b1; op = OP_MULTU; a = 32'h1234; b = 32'h10;
        next_cycle();
        start = 1'b0;
        repeat (19) next_cycle();
        check("pre_rst_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        check("mid_rst_ctrl", {61'd0, busy, done, divzero}, 64'd0);
        check("mid_rst_hilo", {hi, lo}, 64'd0);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            next_cycle();
            if (done || busy) seen++;
        end
        check("mid_rst_nodone", 64'(seen), 64'd0);
        check("mid_rst_hilo_end", {hi, lo}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
